// File: rtl/jedro_1_mem_responder_if.sv
// Core-to-memory req/gnt/rvalid bus bundle.
// master = core side, slave = memory responder side.
interface jedro_1_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/jedro_1_mem_responder.sv
// Memory responder: word RAM with byte-enable writes, fixed-latency
// pipelined responses and error responses for out-of-range addresses.
// Ports: clk_i, rstn_i (async active-low), stall_i (hold gnt low),
//        bus (slave side of the req/gnt/rvalid interface).
module jedro_1_mem_responder #(
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          stall_i,
    jedro_1_mem_responder_if.slave        bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int LAT = READ_LATENCY;

    logic [31:0]   mem [MEM_WORDS];
    logic [29:0]   word;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic          unused_addr;

    logic [LAT-1:0] pv;
    logic [LAT-1:0] pe;
    logic [31:0]    pd [LAT];

    assign word        = bus.addr_i[31:2];
    assign idx         = word[AW-1:0];
    assign in_range    = (word >> AW) == '0;
    assign unused_addr = ^bus.addr_i[1:0];

    assign bus.gnt_o = bus.req_i & ~stall_i & rstn_i;
    assign accept    = bus.req_i & bus.gnt_o;

    // RAM is never reset; writes accepted before a reset persist
    always_ff @(posedge clk_i) begin
        if (accept && bus.we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_i[k]) begin
                    mem[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Stage 0 captures the response at the accept edge; an idle
    // cycle loads an all-zero entry so idle outputs stay zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pe[0] <= accept & ~in_range;
            pd[0] <= (accept && !bus.we_i && in_range) ? mem[idx] : '0;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign bus.rvalid_o = pv[LAT-1];
    assign bus.err_o    = pe[LAT-1];
    assign bus.rdata_o  = pd[LAT-1];
endmodule
